// File: rtl/fifo_sync_ctrl_ram.sv
// Single-clock FIFO with pointer/occupancy control, registered flags and an
// inferred synchronous-read storage array. Read data passes through one
// (PIPE=0) or two (PIPE=1) register stages after the RAM read register.
// The storage array and its read register carry no reset so they map onto
// block RAM.
module fifo_sync_ctrl_ram #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 128,
    parameter int PIPE      = 1,
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 8
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   CLR,
    input  logic                   WE,
    input  logic [WIDTH-1:0]       DATA,
    input  logic                   RE,
    output logic [WIDTH-1:0]       Q,
    output logic                   RVALID,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic                   AFULL,
    output logic                   AEMPTY,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   OVERFLOW,
    output logic                   UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_TH_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_TH_C = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] ram_rd;
    logic             rd_v1;
    logic [WIDTH-1:0] out_d;
    logic             out_v;

    // Accept decisions use the flags registered this cycle; flush overrides both.
    always_comb begin
        wr_acc    = WE && !FULL && !CLR;
        rd_acc    = RE && !EMPTY && !CLR;
        count_nxt = COUNT;
        if (CLR) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = COUNT + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = COUNT - CW'(1);
        end
    end

    // Pointers, occupancy, flags and strobes, all reflecting the state after this edge.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr      <= '0;
            rptr      <= '0;
            COUNT     <= '0;
            FULL      <= 1'b0;
            EMPTY     <= 1'b1;
            AFULL     <= 1'b0;
            AEMPTY    <= 1'b1;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (CLR) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + AW'(1);
                if (rd_acc) rptr <= rptr + AW'(1);
            end
            COUNT     <= count_nxt;
            FULL      <= (count_nxt == DEPTH_C);
            EMPTY     <= (count_nxt == '0);
            AFULL     <= (count_nxt >= AFULL_TH_C);
            AEMPTY    <= (count_nxt <= AEMPTY_TH_C);
            OVERFLOW  <= WE && FULL && !CLR;
            UNDERFLOW <= RE && EMPTY && !CLR;
        end
    end

    // Storage array with registered read port; no reset so it infers block RAM.
    always_ff @(posedge CLOCK) begin
        if (wr_acc) mem[wptr] <= DATA;
        if (rd_acc) ram_rd <= mem[rptr];
    end

    // Tracks which RAM read-register loads carry a real read; not cleared by flush.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) rd_v1 <= 1'b0;
        else       rd_v1 <= rd_acc;
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic [WIDTH-1:0] d2;
            logic             v2;

            // Extra register stage between the RAM read register and the output.
            always_ff @(posedge CLOCK or posedge RESET) begin
                if (RESET) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    if (rd_v1) d2 <= ram_rd;
                    v2 <= rd_v1;
                end
            end

            assign out_d = d2;
            assign out_v = v2;
        end else begin : g_nopipe
            assign out_d = ram_rd;
            assign out_v = rd_v1;
        end
    endgenerate

    // Output register: Q holds the last word read, RVALID pulses once per read.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            Q      <= '0;
            RVALID <= 1'b0;
        end else begin
            if (out_v) Q <= out_d;
            RVALID <= out_v;
        end
    end

endmodule
